// File: rtl/team_09_pkg.sv
// Shared types and default sizing for the team_09 GPIO serial receiver.
package team_09_pkg;

  typedef enum logic [0:0] {IDLE, SHIFT} rx_state_t;

  localparam int unsigned RX_DATA_W     = 8;
  localparam int unsigned RX_FIFO_DEPTH = 4;
  localparam int unsigned RX_SYNC_STG   = 2;

endpackage

// File: rtl/team_09_rx_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two so pointers wrap naturally.
module team_09_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/team_09_gpio_rx.sv
// 3-wire GPIO serial receiver: synchronizers, edge detect, framing FSM and error flags.
// Optional even-parity bit per word when TEAM09_RX_PARITY_EN is defined (adds par_err port).
module team_09_gpio_rx
  import team_09_pkg::*;
#(
  parameter int unsigned DATA_W     = RX_DATA_W,
  parameter int unsigned FIFO_DEPTH = RX_FIFO_DEPTH,
  parameter int unsigned SYNC_STG   = RX_SYNC_STG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gpio_sclk,
  input  logic                          gpio_sdata,
  input  logic                          gpio_scsn,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          ovf_err,
  input  logic                          clr_err
`ifdef TEAM09_RX_PARITY_EN
  ,
  output logic                          par_err
`endif
);

`ifdef TEAM09_RX_PARITY_EN
  localparam int unsigned NBITS = DATA_W + 1;
`else
  localparam int unsigned NBITS = DATA_W;
`endif
  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  logic [SYNC_STG-1:0] sclk_sync_q, sdata_sync_q, scsn_sync_q;
  logic                sclk_dly_q, scsn_dly_q;
  logic                sclk_s, sdata_s, scsn_s;
  logic                sclk_rise, scsn_fall, scsn_rise;

  rx_state_t           state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                word_done, push, ovf_set, fifo_full, fifo_empty;
  logic [DATA_W-1:0]   push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      scsn_sync_q  <= '1;
      sclk_dly_q   <= 1'b0;
      scsn_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STG-2:0], gpio_sclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STG-2:0], gpio_sdata};
      scsn_sync_q  <= {scsn_sync_q[SYNC_STG-2:0], gpio_scsn};
      sclk_dly_q   <= sclk_s;
      scsn_dly_q   <= scsn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign sdata_s   = sdata_sync_q[SYNC_STG-1];
  assign scsn_s    = scsn_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_s && !sclk_dly_q;
  assign scsn_fall = !scsn_s && scsn_dly_q;
  assign scsn_rise = scsn_s && !scsn_dly_q;

  assign word_done = (state_q == SHIFT) && sclk_rise && (bit_cnt_q == CNT_W'(NBITS - 1));

`ifdef TEAM09_RX_PARITY_EN
  logic par_bad;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign par_bad   = ^{shreg_q, sdata_s};
  assign push_word = shreg_q;
  assign push      = word_done && !par_bad;
`else
  assign push_word = {shreg_q[DATA_W-2:0], sdata_s};
  assign push      = word_done;
`endif

  // A full FIFO can only take a word if the consumer pops in the same cycle.
  assign ovf_set = push && fifo_full && !rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
`ifdef TEAM09_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      if (clr_err) begin
        frame_err <= 1'b0;
        ovf_err   <= 1'b0;
`ifdef TEAM09_RX_PARITY_EN
        par_err   <= 1'b0;
`endif
      end
      if (ovf_set) ovf_err <= 1'b1;
`ifdef TEAM09_RX_PARITY_EN
      if (word_done && par_bad) par_err <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          if (scsn_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            // The parity bit is checked but never shifted into the word.
            if (bit_cnt_q < CNT_W'(DATA_W)) shreg_q <= {shreg_q[DATA_W-2:0], sdata_s};
            bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
          end
          if (scsn_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            if (!word_done && (sclk_rise || bit_cnt_q != '0)) frame_err <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  team_09_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_team_09_gpio_rx.sv
// Directed bench for team_09_gpio_rx; also covers the TEAM09_RX_PARITY_EN build.
`timescale 1ns/1ps
module tb_team_09_gpio_rx;

  localparam time HALF = 500;  // 1 MHz serial clock
`ifdef TEAM09_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, sclk, sdata, scsn, rx_ready, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, ovf_err;
  logic [2:0] rx_count;
`ifdef TEAM09_RX_PARITY_EN
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;

  always #12.5 clk = ~clk;

  team_09_gpio_rx dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_sclk  (sclk),
    .gpio_sdata (sdata),
    .gpio_scsn  (scsn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .ovf_err    (ovf_err),
    .clr_err    (clr_err)
`ifdef TEAM09_RX_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // timed: watch rx_valid for at most 4 clk cycles after this rise.
  task automatic send_bit(input logic b, input bit timed, input logic [7:0] exp);
    int n;
    sdata = b;
    #HALF;
    if (timed) @(negedge clk);
    sclk = 1'b1;
    if (timed) begin
      n = 0;
      while (!rx_valid && n < 4) begin
        @(negedge clk);
        n++;
      end
      check("latency_valid", rx_valid, 1);
      check("latency_data", rx_data, exp);
    end
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit bad_par, input bit timed);
    for (int i = 7; i >= 0; i--) send_bit(w[i], timed && (i == 0) && !PAR, w);
    if (PAR) send_bit((^w) ^ bad_par, timed, w);
  endtask

  task automatic frame_begin();
    scsn = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    scsn = 1'b1;
    #(4 * HALF);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; sdata = 1'b0; scsn = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_count", rx_count, 0);
    check("rst_data", rx_data, 0);
    rst = 1'b0;

    // 1: sclk activity with scsn high is ignored
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 8'h00);
    #HALF;
    check("idle_valid", rx_valid, 0);
    check("idle_count", rx_count, 0);
    check("idle_ferr", frame_err, 0);
    check("idle_ovf", ovf_err, 0);

    // 2: single word with latency bound
    frame_begin();
    send_word(8'hA5, 1'b0, 1'b1);
    frame_end();
    check("a5_count", rx_count, 1);
    pop_check("a5_data", 8'hA5);
    check("a5_popped", rx_valid, 0);

    // 3: three back-to-back words in one frame
    frame_begin();
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    send_word(8'h56, 1'b0, 1'b0);
    frame_end();
    check("b2b_count", rx_count, 3);
    check("b2b_ferr", frame_err, 0);
    pop_check("b2b_0", 8'h12);
    pop_check("b2b_1", 8'h34);
    pop_check("b2b_2", 8'h56);
    check("b2b_empty", rx_valid, 0);

    // 4: overflow keeps the first four words
    frame_begin();
    for (int i = 1; i <= 6; i++) send_word(8'(i), 1'b0, 1'b0);
    frame_end();
    check("ovf_count", rx_count, 4);
    check("ovf_flag", ovf_err, 1);
    for (int i = 1; i <= 4; i++) pop_check("ovf_word", 8'(i));
    check("ovf_empty", rx_valid, 0);
    check("ovf_sticky", ovf_err, 1);
    pulse_clr();
    check("ovf_clr", ovf_err, 0);

    // 5: partial frame then a clean frame
    frame_begin();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 8'h00);
    frame_end();
    check("part_valid", rx_valid, 0);
    check("part_ferr", frame_err, 1);
    frame_begin();
    send_word(8'h3C, 1'b0, 1'b0);
    frame_end();
    check("part_next_count", rx_count, 1);
    pop_check("part_next_data", 8'h3C);
    pulse_clr();
    check("ferr_clr", frame_err, 0);

    // 6: reset mid-frame with a word already buffered
    frame_begin();
    send_word(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    scsn = 1'b1;
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", rx_valid, 0);
    check("mrst_count", rx_count, 0);
    check("mrst_data", rx_data, 0);
    check("mrst_ferr", frame_err, 0);
    #(2 * HALF);
    frame_begin();
    send_word(8'h81, PAR, 1'b0);
    frame_end();
`ifdef TEAM09_RX_PARITY_EN
    check("par_err", par_err, 1);
    check("par_valid", rx_valid, 0);
`else
    check("post_rst_count", rx_count, 1);
    pop_check("post_rst_data", 8'h81);
`endif
    check("post_rst_ferr", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
